// File: rtl/apb_burst_bridge_pkg.sv
// Shared types and register-map constants for the APB-to-burst bridge.
package apb_burst_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TX_SEND = 2'd1,
    ST_RX_RECV = 2'd2
  } state_t;

  localparam int REG_CTRL   = 'h00;
  localparam int REG_LEN    = 'h04;
  localparam int REG_STATUS = 'h08;
  localparam int REG_TXDATA = 'h0C;
  localparam int REG_RXDATA = 'h10;

  localparam int CTRL_START_TX = 0;
  localparam int CTRL_START_RX = 1;
  localparam int CTRL_FLUSH    = 2;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DIR      = 1;
  localparam int STAT_ERR      = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_RX_EMPTY = 4;
  localparam int STAT_TX_CNT   = 8;
  localparam int STAT_RX_CNT   = 16;

endpackage

// File: rtl/bridge_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy count.
module bridge_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_burst_bridge.sv
// Zero-wait-state APB register file bridging a TX FIFO to an outbound burst
// and an inbound burst to an RX FIFO, with length-mismatch error tracking.
module apb_burst_bridge
  import apb_burst_bridge_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr,
  output logic              apb_rd_done,
  output logic              idle,
  output logic              burst_valid,
  output logic [DATA_W-1:0] data_burst_out,
  output logic              burst_last,
  input  logic              burst_ready,
  output logic [LEN_W-1:0]  db_length,
  input  logic              db_valid,
  input  logic [DATA_W-1:0] data_burst_in,
  input  logic              last,
  output logic              db_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state, next_state;
  logic [LEN_W-1:0]  len_reg, len_lat, beat;
  logic              err;
  logic              access, apb_wr, apb_rd, in_idle;
  logic [ADDR_W-1:0] addr;
  logic              hit_ctrl, hit_len, hit_status, hit_tx, hit_rx;
  logic              ctrl_both, ctrl_ok, start_tx, start_rx, start_busy, flush;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [CNT_W-1:0]  tx_count, rx_count;
  logic [DATA_W-1:0] tx_head, rx_head, status;
  logic              at_len, rx_end, rx_mismatch;

  assign access  = psel & penable;
  assign apb_wr  = access & pwrite;
  assign apb_rd  = access & ~pwrite;
  assign in_idle = (state == ST_IDLE);
  assign addr    = paddr & ~ADDR_W'(3);

  assign hit_ctrl   = (addr == ADDR_W'(REG_CTRL));
  assign hit_len    = (addr == ADDR_W'(REG_LEN));
  assign hit_status = (addr == ADDR_W'(REG_STATUS));
  assign hit_tx     = (addr == ADDR_W'(REG_TXDATA));
  assign hit_rx     = (addr == ADDR_W'(REG_RXDATA));

  // A write requesting both directions is rejected outright, flush included.
  assign ctrl_both  = pwdata[CTRL_START_TX] & pwdata[CTRL_START_RX];
  assign ctrl_ok    = apb_wr & hit_ctrl & ~ctrl_both;
  assign start_tx   = ctrl_ok & in_idle & pwdata[CTRL_START_TX];
  assign start_rx   = ctrl_ok & in_idle & pwdata[CTRL_START_RX];
  assign start_busy = ctrl_ok & ~in_idle & (pwdata[CTRL_START_TX] | pwdata[CTRL_START_RX]);
  assign flush      = ctrl_ok & in_idle & pwdata[CTRL_FLUSH];

  assign burst_valid    = (state == ST_TX_SEND) & ~tx_empty;
  assign data_burst_out = burst_valid ? tx_head : '0;
  assign at_len         = (beat == len_lat);
  assign burst_last     = (state == ST_TX_SEND) & at_len;
  assign tx_pop         = burst_valid & burst_ready;
  assign tx_push        = apb_wr & hit_tx;

  assign db_ready    = (state == ST_RX_RECV) & ~rx_full;
  assign rx_push     = db_valid & db_ready;
  assign rx_end      = rx_push & (last | at_len);
  assign rx_mismatch = rx_push & (last ^ at_len);
  assign rx_pop      = apb_rd & hit_rx;
  assign apb_rd_done = rx_pop & ~rx_empty;

  assign db_length = in_idle ? '0 : len_lat;
  assign idle      = in_idle & tx_empty & rx_empty;

  bridge_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(tx_push), .wdata(pwdata),
    .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  bridge_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(rx_push), .wdata(data_burst_in),
    .pop(rx_pop), .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_tx)      next_state = ST_TX_SEND;
        else if (start_rx) next_state = ST_RX_RECV;
      end
      ST_TX_SEND: if (tx_pop && burst_last) next_state = ST_IDLE;
      ST_RX_RECV: if (rx_end) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // The beat counter holds on the final beat so LEN at its maximum never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg <= '0;
      len_lat <= '0;
      beat    <= '0;
      err     <= 1'b0;
    end else begin
      if (apb_wr && hit_len) len_reg <= pwdata[LEN_W-1:0];
      if (start_tx || start_rx) begin
        len_lat <= len_reg;
        beat    <= '0;
      end else if ((tx_pop && !burst_last) || (rx_push && !rx_end)) begin
        beat <= beat + 1'b1;
      end
      if (start_busy || rx_mismatch)                  err <= 1'b1;
      else if (apb_wr && hit_status && pwdata[STAT_ERR]) err <= 1'b0;
    end
  end

  always_comb begin
    status                          = '0;
    status[STAT_BUSY]               = ~in_idle;
    status[STAT_DIR]                = (state == ST_RX_RECV);
    status[STAT_ERR]                = err;
    status[STAT_TX_FULL]            = tx_full;
    status[STAT_RX_EMPTY]           = rx_empty;
    status[STAT_TX_CNT +: 8]        = 8'(tx_count);
    status[STAT_RX_CNT +: 8]        = 8'(rx_count);
  end

  always_comb begin
    pslverr = 1'b0;
    prdata  = '0;
    if (access) begin
      if (hit_ctrl) begin
        pslverr = ~pwrite | ctrl_both;
      end else if (hit_len) begin
        if (!pwrite) prdata = DATA_W'(len_reg);
      end else if (hit_status) begin
        if (!pwrite) prdata = status;
      end else if (hit_tx) begin
        pslverr = ~pwrite | tx_full;
      end else if (hit_rx) begin
        pslverr = pwrite | rx_empty;
        if (!pwrite && !rx_empty) prdata = rx_head;
      end else begin
        pslverr = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_burst_bridge.sv
// Self-checking bench: directed scenarios plus randomized bursts, all checked
// against a transaction-level queue model of the bridge.
module tb_apb_burst_bridge;

  localparam int DEPTH  = 16;
  localparam int M_IDLE = 0;
  localparam int M_TX   = 1;
  localparam int M_RX   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pslverr, apb_rd_done, idle;
  logic        burst_valid, burst_last;
  logic [31:0] data_burst_out;
  logic        burst_ready = 1'b0;
  logic [3:0]  db_length;
  logic        db_valid = 1'b0;
  logic [31:0] data_burst_in = '0;
  logic        last = 1'b0;
  logic        db_ready;

  int          errors = 0;
  int          checks = 0;

  int          m_state, m_len, m_lat, m_beat;
  logic        m_err;
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] rx_src[$];
  int          rx_last_idx;

  always #5 clk = ~clk;

  apb_burst_bridge dut (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr),
    .apb_rd_done(apb_rd_done), .idle(idle), .burst_valid(burst_valid),
    .data_burst_out(data_burst_out), .burst_last(burst_last),
    .burst_ready(burst_ready), .db_length(db_length), .db_valid(db_valid),
    .data_burst_in(data_burst_in), .last(last), .db_ready(db_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s: observed=still busy expected=burst complete", tag);
  endtask

  function automatic logic [31:0] model_status();
    return {8'h00, 8'(rx_q.size()), 8'(tx_q.size()), 3'b000,
            rx_q.size() == 0, tx_q.size() == DEPTH, m_err,
            m_state == M_RX, m_state != M_IDLE};
  endfunction

  function automatic logic model_idle();
    return (m_state == M_IDLE) && (tx_q.size() == 0) && (rx_q.size() == 0);
  endfunction

  // Register-map rules applied to the queue model for one APB transfer.
  task automatic model_access(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                              output logic e_err, output logic [31:0] e_rd,
                              output logic e_done);
    logic [7:0] a;
    a      = {addr[7:2], 2'b00};
    e_err  = 1'b0;
    e_rd   = '0;
    e_done = 1'b0;
    case (a)
      8'h00: begin
        if (!wr || (wd[0] && wd[1])) e_err = 1'b1;
        else if (m_state == M_IDLE) begin
          if (wd[2]) begin tx_q.delete(); rx_q.delete(); end
          if (wd[0] || wd[1]) begin
            m_state = wd[0] ? M_TX : M_RX;
            m_lat   = m_len;
            m_beat  = 0;
          end
        end else if (wd[0] || wd[1]) m_err = 1'b1;
      end
      8'h04: if (wr) m_len = int'(wd[3:0]); else e_rd = 32'(m_len);
      8'h08: if (wr) begin if (wd[2]) m_err = 1'b0; end else e_rd = model_status();
      8'h0C: begin
        if (!wr || tx_q.size() == DEPTH) e_err = 1'b1;
        else tx_q.push_back(wd);
      end
      8'h10: begin
        if (wr || rx_q.size() == 0) e_err = 1'b1;
        else begin e_rd = rx_q.pop_front(); e_done = 1'b1; end
      end
      default: e_err = 1'b1;
    endcase
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                               input logic [31:0] wd, input string tag);
    logic e_err, e_done, o_err, o_done;
    logic [31:0] e_rd, o_rd;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    #1;
    o_rd = prdata; o_err = pslverr; o_done = apb_rd_done;
    model_access(wr, addr, wd, e_err, e_rd, e_done);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    checkOutput({tag, "_pslverr"}, 32'(o_err), 32'(e_err));
    checkOutput({tag, "_prdata"}, o_rd, e_rd);
    checkOutput({tag, "_rd_done"}, 32'(o_done), 32'(e_done));
  endtask

  task automatic run_tx(input bit rand_ready);
    int cyc;
    cyc = 0;
    while (m_state == M_TX && cyc < 300) begin
      logic exp_valid, exp_last, rdy;
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      burst_ready = rdy;
      #1;
      exp_valid = (tx_q.size() > 0);
      checkOutput("tx_valid", 32'(burst_valid), 32'(exp_valid));
      checkOutput("tx_db_length", 32'(db_length), 32'(m_lat));
      if (exp_valid) begin
        exp_last = (m_beat == m_lat);
        checkOutput("tx_data", data_burst_out, tx_q[0]);
        checkOutput("tx_last", 32'(burst_last), 32'(exp_last));
        if (rdy) begin
          void'(tx_q.pop_front());
          if (exp_last) m_state = M_IDLE;
          else m_beat++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    burst_ready = 1'b0;
    if (m_state == M_TX) timeoutFail("tx_timeout");
    #1;
    checkOutput("tx_end_idle", 32'(idle), 32'(model_idle()));
    checkOutput("tx_end_valid", 32'(burst_valid), 32'h0);
  endtask

  task automatic run_rx(input bit rand_valid);
    int cyc, idx;
    cyc = 0;
    idx = 0;
    while (m_state == M_RX && cyc < 300) begin
      logic v, exp_rdy, lst;
      v   = (idx < rx_src.size()) && (rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
      lst = (idx == rx_last_idx);
      db_valid = v;
      if (v) data_burst_in = rx_src[idx];
      else   data_burst_in = $urandom;
      last = v & lst;
      #1;
      exp_rdy = (rx_q.size() < DEPTH);
      checkOutput("rx_ready", 32'(db_ready), 32'(exp_rdy));
      checkOutput("rx_db_length", 32'(db_length), 32'(m_lat));
      if (v && exp_rdy) begin
        rx_q.push_back(rx_src[idx]);
        idx++;
        if (lst || m_beat == m_lat) begin
          if (lst != (m_beat == m_lat)) m_err = 1'b1;
          m_state = M_IDLE;
        end else m_beat++;
      end
      @(negedge clk);
      cyc++;
    end
    db_valid = 1'b0;
    last = 1'b0;
    if (m_state == M_RX) timeoutFail("rx_timeout");
    #1;
    checkOutput("rx_end_ready", 32'(db_ready), 32'h0);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    @(negedge clk);
    m_state = M_IDLE; m_len = 0; m_lat = 0; m_beat = 0; m_err = 1'b0;
    tx_q.delete();
    rx_q.delete();
    #1;
    checkOutput("rst_burst_valid", 32'(burst_valid), 32'h0);
    checkOutput("rst_data_out", data_burst_out, 32'h0);
    checkOutput("rst_burst_last", 32'(burst_last), 32'h0);
    checkOutput("rst_db_length", 32'(db_length), 32'h0);
    checkOutput("rst_db_ready", 32'(db_ready), 32'h0);
    checkOutput("rst_prdata", prdata, 32'h0);
    checkOutput("rst_pslverr", 32'(pslverr), 32'h0);
    checkOutput("rst_rd_done", 32'(apb_rd_done), 32'h0);
    checkOutput("rst_idle", 32'(idle), 32'h1);
    rst = 1'b0;
  endtask

  task automatic drainRx(input string tag);
    while (rx_q.size() > 0) applyStimulus(1'b0, 8'h10, 32'h0, tag);
  endtask

  initial begin
    $display("[TB] apb_burst_bridge bench starting");
    resetDut();

    // TX burst of four beats with the sink always ready
    applyStimulus(1'b1, 8'h04, 32'd3, "tx4_len");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h0C, 32'hA0 + 32'(i), "tx4_push");
    burst_ready = 1'b1;
    applyStimulus(1'b1, 8'h00, 32'h1, "tx4_start");
    run_tx(1'b0);

    // RX burst of two beats, then read back and underflow
    applyStimulus(1'b1, 8'h04, 32'd1, "rx2_len");
    applyStimulus(1'b1, 8'h00, 32'h2, "rx2_start");
    rx_src = '{32'h11, 32'h22};
    rx_last_idx = 1;
    run_rx(1'b1);
    applyStimulus(1'b0, 8'h10, 32'h0, "rx2_pop0");
    applyStimulus(1'b0, 8'h10, 32'h0, "rx2_pop1");
    applyStimulus(1'b0, 8'h10, 32'h0, "rx2_underflow");

    // Early last: length mismatch sets the sticky error, W1C clears it
    applyStimulus(1'b1, 8'h04, 32'd3, "mm_len");
    applyStimulus(1'b1, 8'h00, 32'h2, "mm_start");
    rx_src = '{32'h31, 32'h32, 32'h33};
    rx_last_idx = 2;
    run_rx(1'b0);
    applyStimulus(1'b0, 8'h08, 32'h0, "mm_status");
    applyStimulus(1'b1, 8'h08, 32'h4, "mm_clear");
    applyStimulus(1'b0, 8'h08, 32'h0, "mm_status_clr");
    drainRx("mm_drain");

    // TX FIFO fill, overflow and flush
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'h0C, $urandom, "fill_push");
    applyStimulus(1'b0, 8'h08, 32'h0, "fill_status");
    applyStimulus(1'b1, 8'h0C, 32'hDEAD, "fill_overflow");
    applyStimulus(1'b0, 8'h08, 32'h0, "fill_status2");
    applyStimulus(1'b1, 8'h00, 32'h4, "flush");
    applyStimulus(1'b0, 8'h08, 32'h0, "flush_status");
    #1;
    checkOutput("flush_idle", 32'(idle), 32'h1);

    // Illegal and odd accesses
    applyStimulus(1'b1, 8'h00, 32'h3, "ill_both_start");
    applyStimulus(1'b0, 8'h08, 32'h0, "ill_status");
    applyStimulus(1'b0, 8'h14, 32'h0, "ill_unmapped");
    applyStimulus(1'b0, 8'h00, 32'h0, "ill_rd_ctrl");
    applyStimulus(1'b0, 8'h0C, 32'h0, "ill_rd_txdata");
    applyStimulus(1'b1, 8'h10, 32'h5, "ill_wr_rxdata");
    applyStimulus(1'b1, 8'h04, 32'd9, "ill_len");
    applyStimulus(1'b0, 8'h07, 32'h0, "ill_len_lowbits");

    // Start while busy sets err without disturbing the running burst
    applyStimulus(1'b1, 8'h04, 32'd2, "busy_len");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h0C, $urandom, "busy_push");
    applyStimulus(1'b1, 8'h00, 32'h1, "busy_start");
    applyStimulus(1'b1, 8'h00, 32'h1, "busy_restart");
    applyStimulus(1'b0, 8'h08, 32'h0, "busy_status");
    run_tx(1'b1);
    applyStimulus(1'b1, 8'h08, 32'h4, "busy_clear");

    // Maximum length RX fills the RX FIFO; a following RX stalls until a pop
    applyStimulus(1'b1, 8'h04, 32'd15, "max_len");
    applyStimulus(1'b1, 8'h00, 32'h2, "max_start");
    rx_src.delete();
    for (int i = 0; i < DEPTH; i++) rx_src.push_back($urandom);
    rx_last_idx = DEPTH - 1;
    run_rx(1'b1);
    applyStimulus(1'b0, 8'h08, 32'h0, "max_status");
    applyStimulus(1'b1, 8'h04, 32'd0, "bp_len");
    applyStimulus(1'b1, 8'h00, 32'h2, "bp_start");
    #1;
    checkOutput("bp_ready_full", 32'(db_ready), 32'h0);
    applyStimulus(1'b0, 8'h10, 32'h0, "bp_pop");
    rx_src = '{32'h55};
    rx_last_idx = 0;
    run_rx(1'b0);
    drainRx("bp_drain");
    applyStimulus(1'b0, 8'h10, 32'h0, "bp_underflow");

    // Randomized bursts in both directions
    for (int it = 0; it < 8; it++) begin
      int len, mode, nb;
      len = $urandom_range(0, 15);
      applyStimulus(1'b1, 8'h04, 32'(len), "rnd_len");
      if (it % 2 == 0) begin
        for (int k = 0; k <= len; k++) applyStimulus(1'b1, 8'h0C, $urandom, "rnd_push");
        applyStimulus(1'b1, 8'h00, 32'h1, "rnd_start_tx");
        run_tx(1'b1);
      end else begin
        mode = $urandom_range(0, 2);
        nb = len + 1;
        rx_last_idx = len;
        if (mode == 1 && len > 0) begin
          rx_last_idx = $urandom_range(0, len - 1);
          nb = rx_last_idx + 1;
        end else if (mode == 2) begin
          rx_last_idx = -1;
        end
        rx_src.delete();
        for (int k = 0; k < nb; k++) rx_src.push_back($urandom);
        applyStimulus(1'b1, 8'h00, 32'h2, "rnd_start_rx");
        run_rx(1'b1);
        applyStimulus(1'b0, 8'h08, 32'h0, "rnd_status");
        drainRx("rnd_pop");
        applyStimulus(1'b1, 8'h08, 32'h4, "rnd_clear");
      end
    end

    // Reset during beat 2 of an 8-beat TX burst
    applyStimulus(1'b1, 8'h04, 32'd7, "rb_len");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h0C, $urandom, "rb_push");
    burst_ready = 1'b1;
    applyStimulus(1'b1, 8'h00, 32'h1, "rb_start");
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("rb_beat_data", data_burst_out, tx_q[0]);
      void'(tx_q.pop_front());
      m_beat++;
      @(negedge clk);
    end
    resetDut();
    burst_ready = 1'b0;
    applyStimulus(1'b0, 8'h08, 32'h0, "rb_status");
    applyStimulus(1'b0, 8'h04, 32'h0, "rb_len_read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
